clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_pkg.sv | 22 ++
 rtl/clock_div_counter.sv | 43 ++++
 rtl/clock_divider.sv | 131 +++++++++++++
 tb/tb_clock_divider.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared state encoding and constants for the clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int   DIV_MIN   = 2;
    localparam int   DIV_RESET = 2;

    localparam logic SQUARE    = 1'b0;
    localparam logic PULSE     = 1'b1;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/clock_div_counter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_counter
//  Description : Phase counter with wrap detection and high-phase comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_div_counter
    import clock_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_wrap,
    output logic             o_out_next
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH:0]   w_high;

    // High-phase length uses one extra bit so N = 2^WIDTH-1 cannot overflow.
    always_comb begin
        o_wrap     = (r_cnt == (i_div - WIDTH'(1)));
        w_cnt_next = o_wrap ? '0 : (r_cnt + WIDTH'(1));
        w_high     = (i_mode == PULSE) ? (WIDTH+1)'(1)
                                       : (({1'b0, i_div} + (WIDTH+1)'(1)) >> 1);
        o_out_next = ({1'b0, w_cnt_next} < w_high);
    end

    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule : clock_div_counter
`default_nettype wire

// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider
//  Description : Programmable glitch-free clock divider with run/drain control.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider
    import clock_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    output logic             out,
    output logic             tick,
    output logic [WIDTH-1:0] div_cur,
    output logic             running
);

    localparam logic [WIDTH-1:0] c_DIV_MIN   = WIDTH'(DIV_MIN);
    localparam logic [WIDTH-1:0] c_DIV_RESET = WIDTH'(DIV_RESET);

    state_e           r_state;
    logic             r_out;
    logic             r_tick;
    logic             r_running;
    logic [WIDTH-1:0] r_div;
    logic             r_mode;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_mode;

    logic [WIDTH-1:0] w_div_clamped;
    logic             w_wrap;
    logic             w_out_next;

    assign w_div_clamped = (div_in < c_DIV_MIN) ? c_DIV_MIN : div_in;

    clock_div_counter #(
        .WIDTH      (WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .i_run      (r_running),
        .i_mode     (r_mode),
        .i_div      (r_div),
        .o_wrap     (w_wrap),
        .o_out_next (w_out_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_out        <= 1'b0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
            r_div        <= c_DIV_RESET;
            r_mode       <= SQUARE;
            r_pend_valid <= 1'b0;
            r_pend_div   <= c_DIV_RESET;
            r_pend_mode  <= SQUARE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_pend_valid <= 1'b0;
                    if (load) begin
                        r_div  <= w_div_clamped;
                        r_mode <= mode_in;
                    end
                    if (en) begin
                        r_state   <= RUN;
                        r_out     <= 1'b1;
                        r_tick    <= 1'b1;
                        r_running <= 1'b1;
                    end else begin
                        r_out     <= 1'b0;
                        r_tick    <= 1'b0;
                        r_running <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    // Ratio/mode only change at a period boundary; a load on
                    // the wrap edge itself takes effect for the new period.
                    if (w_wrap) begin
                        if (load) begin
                            r_div  <= w_div_clamped;
                            r_mode <= mode_in;
                        end else if (r_pend_valid) begin
                            r_div  <= r_pend_div;
                            r_mode <= r_pend_mode;
                        end
                        r_pend_valid <= 1'b0;
                    end else if (load) begin
                        r_pend_valid <= 1'b1;
                        r_pend_div   <= w_div_clamped;
                        r_pend_mode  <= mode_in;
                    end

                    if (w_wrap && (r_state == DRAIN) && !en) begin
                        r_state   <= IDLE;
                        r_out     <= 1'b0;
                        r_tick    <= 1'b0;
                        r_running <= 1'b0;
                    end else begin
                        r_state   <= en ? RUN : DRAIN;
                        r_out     <= w_out_next;
                        r_tick    <= w_wrap;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_out     <= 1'b0;
                    r_tick    <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign out     = r_out;
    assign tick    = r_tick;
    assign div_cur = r_div;
    assign running = r_running;

endmodule : clock_divider
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_divider
//  Description : Directed vector table plus corner sequences for clock_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] div_in;
    logic       mode_in;
    logic       out;
    logic       tick;
    logic [7:0] div_cur;
    logic       running;

    int tests;
    int fails;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic [7:0] div;
        logic       mode;
        logic       e_out;
        logic       e_tick;
        logic       e_run;
        logic [7:0] e_div;
    } vec_t;

    vec_t vecs[80];
    int   nv;

    clock_divider #(
        .WIDTH   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .mode_in (mode_in),
        .out     (out),
        .tick    (tick),
        .div_cur (div_cur),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic l, input logic [7:0] d,
                       input logic m, input logic eo, input logic et, input logic er,
                       input logic [7:0] ed);
        vecs[nv] = '{r, e, l, d, m, eo, et, er, ed};
        nv++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l,
                         input logic [7:0] d, input logic m);
        reset   = r;
        en      = e;
        load    = l;
        div_in  = d;
        mode_in = m;
    endtask

    // Counts cycles from the current tick to the next one, and out-high cycles within.
    task automatic measure(output int period, output int high);
        period = 1;
        high   = out ? 1 : 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (tick) break;
            period++;
            high += out ? 1 : 0;
        end
    endtask

    initial begin
        int per;
        int hi;
        tests = 0;
        fails = 0;
        nv    = 0;
        drive(1, 0, 0, 8'd0, 0);

        // rst en ld div mode | out tick run div_cur  (outputs after the edge)
        repeat (3) add(1,0,0,8'd0,0, 0,0,0,8'd2);
        add(0,0,1,8'd4,0, 0,0,0,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,1,1,8'd5,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd5);
        add(0,1,0,8'd0,0, 1,0,1,8'd5);
        add(0,1,0,8'd0,0, 1,0,1,8'd5);
        add(0,1,0,8'd0,0, 0,0,1,8'd5);
        add(0,1,1,8'd3,1, 0,0,1,8'd5);
        add(0,1,0,8'd0,0, 1,1,1,8'd3);
        add(0,1,0,8'd0,0, 0,0,1,8'd3);
        add(0,1,0,8'd0,0, 0,0,1,8'd3);
        add(0,1,0,8'd0,0, 1,1,1,8'd3);
        add(0,1,0,8'd0,0, 0,0,1,8'd3);
        add(0,1,1,8'd4,0, 0,0,1,8'd3);
        add(0,1,0,8'd0,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,1,1,8'd6,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd6);
        add(0,1,0,8'd0,0, 1,0,1,8'd6);
        add(0,1,0,8'd0,0, 1,0,1,8'd6);
        add(0,1,0,8'd0,0, 0,0,1,8'd6);
        add(0,1,0,8'd0,0, 0,0,1,8'd6);
        add(0,1,0,8'd0,0, 0,0,1,8'd6);
        add(0,1,1,8'd4,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,0,8'd4);
        add(0,0,0,8'd0,0, 0,0,0,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 0,0,1,8'd4);
        add(0,1,0,8'd0,0, 1,1,1,8'd4);
        add(0,1,0,8'd0,0, 1,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,1,8'd4);
        add(0,0,0,8'd0,0, 0,0,0,8'd4);
        add(0,0,1,8'd0,0, 0,0,0,8'd2);
        add(0,1,0,8'd0,0, 1,1,1,8'd2);
        add(0,1,0,8'd0,0, 0,0,1,8'd2);
        add(0,1,1,8'd6,0, 1,1,1,8'd6);
        add(0,1,0,8'd0,0, 1,0,1,8'd6);
        add(0,1,0,8'd0,0, 1,0,1,8'd6);
        add(1,1,1,8'd9,1, 0,0,0,8'd2);
        add(1,1,1,8'd9,1, 0,0,0,8'd2);
        add(0,0,0,8'd0,0, 0,0,0,8'd2);
        add(0,1,0,8'd0,0, 1,1,1,8'd2);
        add(0,1,0,8'd0,0, 0,0,1,8'd2);
        add(0,1,0,8'd0,0, 1,1,1,8'd2);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].div, vecs[i].mode);
            step();
            check($sformatf("vec%0d {out,tick,run,div}", i),
                  int'({out, tick, running, div_cur}),
                  int'({vecs[i].e_out, vecs[i].e_tick, vecs[i].e_run, vecs[i].e_div}));
        end

        // Maximum ratio: 255 cycles per period, 128 high.
        drive(1, 0, 0, 8'd0, 0);
        step();
        drive(0, 0, 1, 8'd1, 0);
        step();
        check("clamp_div1", int'(div_cur), 2);
        drive(0, 0, 1, 8'd255, 0);
        step();
        drive(0, 1, 0, 8'd0, 0);
        step();
        check("max_first_tick", int'(tick), 1);
        measure(per, hi);
        check("max_period", per, 255);
        check("max_high", hi, 128);

        // Several loads within one period: the last one wins at the wrap.
        drive(1, 0, 0, 8'd0, 0);
        step();
        drive(0, 0, 1, 8'd4, 0);
        step();
        drive(0, 1, 0, 8'd0, 0);
        step();
        step();
        drive(0, 1, 1, 8'd7, 0);
        step();
        drive(0, 1, 1, 8'd3, 0);
        step();
        check("multi_load_hold", int'(div_cur), 4);
        drive(0, 1, 0, 8'd0, 0);
        step();
        check("multi_load_div", int'(div_cur), 3);
        check("multi_load_tick", int'(tick), 1);
        measure(per, hi);
        check("multi_load_period", per, 3);
        check("multi_load_high", hi, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_clock_divider
`default_nettype wire
